l2_port_arbiter: RTL and testbench
==================================

# l2_port_arbiter

Shares the single L2 request port between `NUM_REQ` L1 cache clients, such as the L1 instruction and L1 data caches. Arbitration is round-robin. Exactly one transaction is outstanding to L2 at a time. The block latches the winning request, drives it to L2 until L2 responds or a timeout expires, then returns a one-cycle response to the winner. It sits between the L1 caches' L2-side request ports and the L2 cache's L1-side port.

## Interface
Parameters:
- `NUM_REQ`, 2, number of L1 clients (2..8)
- `ADDR_WIDTH`, 32, request address width
- `DATA_WIDTH`, 32, data width
- `TIMEOUT_CYCLES`, 256, maximum cycles in BUSY without an L2 response; 0 disables the timeout

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  NUM_REQ  per-client request, held until that client's `resp_valid`
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; client i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_op`  in  NUM_REQ  0 = read, 1 = write (write-back)
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data
- `resp_valid`  out  NUM_REQ  one-hot, one-cycle response pulse
- `resp_data`  out  DATA_WIDTH  read data; valid with `resp_valid`
- `resp_err`  out  1  timeout indication; valid with `resp_valid`
- `l2_req_valid`  out  1  request to L2
- `l2_req_addr`  out  ADDR_WIDTH  latched address
- `l2_req_op`  out  1  latched op
- `l2_write_data`  out  DATA_WIDTH  latched write data
- `l2_resp_valid`  in  1  L2 response strobe
- `l2_resp_data`  in  DATA_WIDTH  L2 read data
- `grant_id`  out  $clog2(NUM_REQ)  current or last winner
- `busy`  out  1  high in BUSY and RESP

## Operation
- States:
  - IDLE: no transaction in flight.
  - BUSY: request driven to L2.
  - RESP: response pulse to the winner.
- IDLE:
  - If any `req_valid` bit is set, pick the winner as the first set bit scanning from `rr_ptr` upward with wrap-around.
  - Latch the winner's addr/op/wdata into the L2 output registers, set `grant_id`, clear the timeout counter, and go to BUSY.
  - Set `rr_ptr` to (winner+1) mod NUM_REQ.
- BUSY:
  - `l2_req_valid` = 1 and the L2 payload is stable throughout.
  - On `l2_resp_valid`: register `resp_data` = `l2_resp_data`, `resp_err` = 0, and go to RESP.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES (nonzero): set `resp_data` = 0, `resp_err` = 1, and go to RESP.
- RESP: `resp_valid[grant_id]` = 1 and `l2_req_valid` = 0; go to IDLE.
- Client rule:
  - A client deasserts `req_valid` on the edge where it samples its `resp_valid` high.
  - The arbiter never re-grants a client in the same cycle as that client's response.
  - The earliest re-arbitration is the IDLE cycle after RESP.
- The payload of a pending (ungranted) client may change freely. Only the value present at the grant edge is used.
- `l2_resp_valid` outside BUSY is ignored. A late response after a timeout is dropped.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates; no wrap.
- Reset values:
  - state = IDLE, `rr_ptr` = 0, `grant_id` = 0.
  - All outputs 0: `resp_valid`, `resp_data`, `resp_err`, `l2_req_valid`, `l2_req_addr`, `l2_req_op`, `l2_write_data`, `busy`.
- Reset mid-transaction abandons it: no response is issued and a subsequent L2 response is ignored.

## Timing
- All outputs are registered.
- `req_valid` sampled in IDLE at edge 0 → `l2_req_valid` high after edge 0.
- `l2_resp_valid` sampled at edge k → `resp_valid` high for exactly one cycle after edge k, and `l2_req_valid` low after edge k.
- Minimum occupancy is 3 cycles per transaction (IDLE, BUSY, RESP) with a 1-cycle L2 response.
- Simultaneous requests: one grant per transaction. A requester waits at most NUM_REQ-1 transactions.
- `l2_resp_valid` in the same cycle the timeout count is reached: the response wins and `resp_err` = 0.

## Structure
- Package `l2_arb_pkg`:
  - `arb_state_t` enum {IDLE, BUSY, RESP}
  - constants `OP_READ` = 1'b0, `OP_WRITE` = 1'b1
- Sub-module `l2_rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector, `ptr`.
  - Outputs: `any`, `winner` index.
  - Instantiated once; `rr_ptr` register stays in the parent.

## Test plan
- Single read: client 0 req addr 0x0000_1040, L2 responds 3 cycles later with 0xDEADBEEF → `l2_req_addr` 0x0000_1040 stable 3 cycles; `resp_valid` = 2'b01 for 1 cycle; `resp_data` 0xDEADBEEF; `resp_err` 0.
- Simultaneous requests from clients 0 and 1, held continuously:
  - Grants alternate 0, 1, 0, 1 starting from reset `rr_ptr` = 0.
  - Each winner's latched payload is seen on L2.
- Write-back: client 1 op 1, wdata 0x1234_5678 → `l2_req_op` 1 and `l2_write_data` 0x1234_5678 held until `l2_resp_valid`; `resp_valid` = 2'b10.
- Timeout: TIMEOUT_CYCLES = 4, L2 silent → RESP after 4 BUSY cycles with `resp_err` 1 and `resp_data` 0. A later `l2_resp_valid` causes no `resp_valid`.
- Reset in BUSY: assert `rst` one cycle mid-transaction → all outputs 0 next cycle. A subsequent `l2_resp_valid` is ignored. The next request is granted from `rr_ptr` 0.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 port arbiter: FSM state encoding and
// request opcodes as seen on the L1/L2 request channels.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/l2_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping around to bit 0.
module l2_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NREQ_W = (IW+1)'(NUM_REQ);

  logic [IW:0]   slot_s;
  logic [IW-1:0] idx_s;

  // Scan from ptr upward, keeping only the first requester found.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    slot_s = '0;
    idx_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_s = {1'b0, ptr} + (IW+1)'(i);
      if (slot_s >= NREQ_W) begin
        idx_s = IW'(slot_s - NREQ_W);
      end else begin
        idx_s = slot_s[IW-1:0];
      end
      if (!any && req[idx_s]) begin
        any    = 1'b1;
        winner = idx_s;
      end else begin
        any    = any;
      end
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 request port among NUM_REQ L1 clients,
// with a single outstanding transaction and an optional response timeout.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]              req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic                            resp_err,
  output logic                            l2_req_valid,
  output logic [ADDR_WIDTH-1:0]           l2_req_addr,
  output logic                            l2_req_op,
  output logic [DATA_WIDTH-1:0]           l2_write_data,
  input  logic                            l2_resp_valid,
  input  logic [DATA_WIDTH-1:0]           l2_resp_data,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [IW-1:0] LAST_ID  = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         grant_id_q, grant_id_d;
  logic [CW-1:0]         to_cnt_q, to_cnt_d;
  logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  logic                  l2_req_valid_q, l2_req_valid_d;
  logic [ADDR_WIDTH-1:0] l2_req_addr_q, l2_req_addr_d;
  logic                  l2_req_op_q, l2_req_op_d;
  logic [DATA_WIDTH-1:0] l2_write_data_q, l2_write_data_d;
  logic                  busy_q, busy_d;

  logic                  pick_any_s;
  logic [IW-1:0]         pick_winner_s;
  logic [CW-1:0]         to_cnt_inc_s;

  l2_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .any    (pick_any_s),
    .winner (pick_winner_s)
  );

  // Saturating so a huge TIMEOUT_CYCLES can never wrap the count.
  assign to_cnt_inc_s = (to_cnt_q == CNT_MAX) ? to_cnt_q : to_cnt_q + CW'(1);

  // Next-state and next-output logic for the IDLE/BUSY/RESP transaction cycle.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_id_d      = grant_id_q;
    to_cnt_d        = to_cnt_q;
    resp_valid_d    = '0;
    resp_data_d     = resp_data_q;
    resp_err_d      = resp_err_q;
    l2_req_valid_d  = l2_req_valid_q;
    l2_req_addr_d   = l2_req_addr_q;
    l2_req_op_d     = l2_req_op_q;
    l2_write_data_d = l2_write_data_q;

    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d         = BUSY;
          grant_id_d      = pick_winner_s;
          rr_ptr_d        = (pick_winner_s == LAST_ID) ? '0 : pick_winner_s + IW'(1);
          to_cnt_d        = '0;
          l2_req_valid_d  = 1'b1;
          l2_req_addr_d   = req_addr[int'(pick_winner_s)*ADDR_WIDTH +: ADDR_WIDTH];
          l2_req_op_d     = req_op[pick_winner_s];
          l2_write_data_d = req_wdata[int'(pick_winner_s)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // A response arriving on the timeout cycle takes priority over the error.
        if (l2_resp_valid) begin
          state_d        = RESP;
          resp_data_d    = l2_resp_data;
          resp_err_d     = 1'b0;
          resp_valid_d   = ONE_HOT0 << grant_id_q;
          l2_req_valid_d = 1'b0;
        end else if (TO_EN && (to_cnt_inc_s == TO_LIMIT)) begin
          state_d        = RESP;
          resp_data_d    = '0;
          resp_err_d     = 1'b1;
          resp_valid_d   = ONE_HOT0 << grant_id_q;
          l2_req_valid_d = 1'b0;
        end else begin
          to_cnt_d = to_cnt_inc_s;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d        = IDLE;
        l2_req_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      grant_id_q      <= '0;
      to_cnt_q        <= '0;
      resp_valid_q    <= '0;
      resp_data_q     <= '0;
      resp_err_q      <= 1'b0;
      l2_req_valid_q  <= 1'b0;
      l2_req_addr_q   <= '0;
      l2_req_op_q     <= OP_READ;
      l2_write_data_q <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_id_q      <= grant_id_d;
      to_cnt_q        <= to_cnt_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      resp_err_q      <= resp_err_d;
      l2_req_valid_q  <= l2_req_valid_d;
      l2_req_addr_q   <= l2_req_addr_d;
      l2_req_op_q     <= l2_req_op_d;
      l2_write_data_q <= l2_write_data_d;
      busy_q          <= busy_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_err      = resp_err_q;
  assign l2_req_valid  = l2_req_valid_q;
  assign l2_req_addr   = l2_req_addr_q;
  assign l2_req_op     = l2_req_op_q;
  assign l2_write_data = l2_write_data_q;
  assign grant_id      = grant_id_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter with a transaction-level reference model
// compared every cycle, plus literal expectations for the main scenarios.
module tb_l2_port_arbiter;
  import l2_arb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_op = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic            l2_resp_valid = 1'b0;
  logic [DW-1:0]   l2_resp_data = '0;
  logic [N-1:0]    persist = '0;

  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_data;
  logic            resp_err;
  logic            l2_req_valid;
  logic [AW-1:0]   l2_req_addr;
  logic            l2_req_op;
  logic [DW-1:0]   l2_write_data;
  logic [0:0]      grant_id;
  logic            busy;

  int n_checks = 0;
  int n_fails  = 0;

  l2_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_op(req_op), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .l2_req_valid(l2_req_valid), .l2_req_addr(l2_req_addr), .l2_req_op(l2_req_op),
    .l2_write_data(l2_write_data),
    .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // in_txn: a transaction is being presented to L2; waited: cycles spent waiting.
  // rsp_next: the cycle after this edge carries the response pulse.
  logic          m_ok = 1'b0;
  logic          m_in_txn = 1'b0;
  logic          m_rsp_now = 1'b0;
  int            m_waited = 0;
  int            m_ptr = 0;
  int            m_pick;
  logic [N-1:0]  e_resp_valid = '0;
  logic [DW-1:0] e_resp_data = '0;
  logic          e_resp_err = 1'b0;
  logic          e_l2_valid = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic          e_op = 1'b0;
  logic [DW-1:0] e_wdata = '0;
  int            e_grant = 0;
  logic          e_busy = 1'b0;

  function automatic int rr_choose(input logic [N-1:0] r, input int ptr);
    for (int d = 0; d < N; d++) begin
      if (r[(ptr + d) % N]) return (ptr + d) % N;
    end
    return -1;
  endfunction

  assign m_pick = rr_choose(req_valid, m_ptr);

  always @(posedge clk) begin
    if (rst) begin
      m_ok <= 1'b1; m_in_txn <= 1'b0; m_rsp_now <= 1'b0; m_waited <= 0; m_ptr <= 0;
      e_resp_valid <= '0; e_resp_data <= '0; e_resp_err <= 1'b0; e_l2_valid <= 1'b0;
      e_addr <= '0; e_op <= 1'b0; e_wdata <= '0; e_grant <= 0; e_busy <= 1'b0;
    end else if (m_ok) begin
      e_resp_valid <= '0;
      if (m_rsp_now) begin
        m_rsp_now <= 1'b0;
        e_busy    <= 1'b0;
      end else if (m_in_txn) begin
        if (l2_resp_valid || (m_waited + 1 >= TO)) begin
          m_in_txn     <= 1'b0;
          m_rsp_now    <= 1'b1;
          e_l2_valid   <= 1'b0;
          e_resp_valid <= N'(1) << e_grant;
          e_resp_data  <= l2_resp_valid ? l2_resp_data : '0;
          e_resp_err   <= !l2_resp_valid;
        end else begin
          m_waited <= m_waited + 1;
        end
      end else if (m_pick >= 0) begin
        m_in_txn   <= 1'b1;
        m_waited   <= 0;
        e_grant    <= m_pick;
        m_ptr      <= (m_pick + 1) % N;
        e_l2_valid <= 1'b1;
        e_busy     <= 1'b1;
        e_addr     <= req_addr[m_pick*AW +: AW];
        e_op       <= req_op[m_pick];
        e_wdata    <= req_wdata[m_pick*DW +: DW];
      end
    end
  end

  // ---------------- checking helpers ----------------
  logic [N-1:0]  s_resp_valid;
  logic [DW-1:0] s_resp_data;
  logic          s_resp_err, s_l2_valid, s_l2_op, s_busy;
  logic [AW-1:0] s_l2_addr;
  logic [DW-1:0] s_l2_wdata;
  logic [0:0]    s_grant;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("m_resp_valid", 64'(resp_valid), 64'(e_resp_valid));
    chk("m_l2_req_valid", 64'(l2_req_valid), 64'(e_l2_valid));
    chk("m_busy", 64'(busy), 64'(e_busy));
    chk("m_grant_id", 64'(grant_id), 64'(e_grant));
    if (e_resp_valid != '0) begin
      chk("m_resp_data", 64'(resp_data), 64'(e_resp_data));
      chk("m_resp_err", 64'(resp_err), 64'(e_resp_err));
    end
    if (e_l2_valid) begin
      chk("m_l2_addr", 64'(l2_req_addr), 64'(e_addr));
      chk("m_l2_op", 64'(l2_req_op), 64'(e_op));
      chk("m_l2_wdata", 64'(l2_write_data), 64'(e_wdata));
    end
  endtask

  // One clock: compare and snapshot mid-cycle, then apply the client rule after the edge.
  task automatic tick();
    @(negedge clk);
    if (m_ok) compare_all();
    s_resp_valid = resp_valid; s_resp_data = resp_data; s_resp_err = resp_err;
    s_l2_valid = l2_req_valid; s_l2_addr = l2_req_addr; s_l2_op = l2_req_op;
    s_l2_wdata = l2_write_data; s_busy = busy; s_grant = grant_id;
    @(posedge clk);
    #1;
    req_valid = (req_valid | persist) & ~s_resp_valid;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp_valid"}, 64'(s_resp_valid), 64'(0));
    chk({tag, "_resp_data"}, 64'(s_resp_data), 64'(0));
    chk({tag, "_resp_err"}, 64'(s_resp_err), 64'(0));
    chk({tag, "_l2_valid"}, 64'(s_l2_valid), 64'(0));
    chk({tag, "_l2_addr"}, 64'(s_l2_addr), 64'(0));
    chk({tag, "_l2_op"}, 64'(s_l2_op), 64'(0));
    chk({tag, "_l2_wdata"}, 64'(s_l2_wdata), 64'(0));
    chk({tag, "_busy"}, 64'(s_busy), 64'(0));
    chk({tag, "_grant"}, 64'(s_grant), 64'(0));
  endtask

  // Wait for a grant, respond on the lat-th BUSY cycle (lat=0: stay silent),
  // and return once the response pulse has been observed.
  task automatic serve(input int lat, input logic [DW-1:0] d, output int busy_n, output int g,
                       output logic [AW-1:0] a0, output logic op0, output logic [DW-1:0] wd0);
    int guard;
    bit done;
    busy_n = 0; g = -1; a0 = '0; op0 = 1'b0; wd0 = '0; guard = 0;
    do begin
      tick();
      guard++;
    end while (s_l2_valid !== 1'b1 && guard < 20);
    chk("grant_seen", 64'(s_l2_valid), 64'(1));
    if (s_l2_valid === 1'b1) begin
      g = int'(s_grant); a0 = s_l2_addr; op0 = s_l2_op; wd0 = s_l2_wdata;
      busy_n = 1; done = 1'b0; guard = 0;
      while (!done) begin
        l2_resp_valid = (lat >= 2) && (busy_n == lat - 1);
        l2_resp_data  = d;
        tick();
        guard++;
        if (s_resp_valid != '0) begin
          done = 1'b1;
        end else if (guard >= 40) begin
          chk("resp_seen", 64'(s_resp_valid != '0), 64'(1));
          done = 1'b1;
        end else if (s_l2_valid === 1'b1) begin
          busy_n++;
          chk("stable_addr", 64'(s_l2_addr), 64'(a0));
          chk("stable_op", 64'(s_l2_op), 64'(op0));
          chk("stable_wdata", 64'(s_l2_wdata), 64'(wd0));
        end
      end
      l2_resp_valid = 1'b0;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int bn, g;
    logic [AW-1:0] a;
    logic op;
    logic [DW-1:0] wd;
    int exp_grant [5] = '{0, 1, 0, 1, 0};

    tick();
    chk_all_zero("reset");
    tick();
    rst = 1'b0;

    // Both clients hold requests: grants alternate from rr_ptr 0.
    req_addr = {32'h0000_2200, 32'h0000_1100};
    persist = 2'b11;
    req_valid = 2'b11;
    for (int t = 0; t < 5; t++) begin
      if (t == 4) persist = 2'b00;
      serve(2, 32'hA000_0000 + DW'(t), bn, g, a, op, wd);
      chk("alt_grant", 64'(g), 64'(exp_grant[t]));
      chk("alt_addr", 64'(a), (t % 2 == 1) ? 64'h2200 : 64'h1100);
    end

    // Single read from client 0, L2 answers on the third BUSY cycle.
    req_addr[31:0] = 32'h0000_1040;
    req_op[0] = OP_READ;
    req_valid = 2'b01;
    serve(3, 32'hDEAD_BEEF, bn, g, a, op, wd);
    chk("rd_busy_cycles", 64'(bn), 64'(3));
    chk("rd_addr", 64'(a), 64'h1040);
    chk("rd_resp_valid", 64'(s_resp_valid), 64'(2'b01));
    chk("rd_resp_data", 64'(s_resp_data), 64'hDEAD_BEEF);
    chk("rd_resp_err", 64'(s_resp_err), 64'(0));

    // Write-back from client 1.
    req_addr[63:32] = 32'h0000_3300;
    req_op[1] = OP_WRITE;
    req_wdata[63:32] = 32'h1234_5678;
    req_valid = 2'b10;
    serve(2, 32'h0, bn, g, a, op, wd);
    chk("wr_grant", 64'(g), 64'(1));
    chk("wr_op", 64'(op), 64'(1));
    chk("wr_wdata", 64'(wd), 64'h1234_5678);
    chk("wr_resp_valid", 64'(s_resp_valid), 64'(2'b10));
    req_op[1] = OP_READ;

    // Response on the same cycle the timeout count is reached: response wins.
    req_addr[31:0] = 32'h0000_1080;
    req_valid = 2'b01;
    serve(4, 32'hCAFE_F00D, bn, g, a, op, wd);
    chk("edge_busy_cycles", 64'(bn), 64'(4));
    chk("edge_resp_err", 64'(s_resp_err), 64'(0));
    chk("edge_resp_data", 64'(s_resp_data), 64'hCAFE_F00D);

    // Silent L2: timeout after 4 BUSY cycles, then a late response is dropped.
    req_valid = 2'b01;
    serve(0, 32'h0, bn, g, a, op, wd);
    chk("to_busy_cycles", 64'(bn), 64'(4));
    chk("to_resp_valid", 64'(s_resp_valid), 64'(2'b01));
    chk("to_resp_err", 64'(s_resp_err), 64'(1));
    chk("to_resp_data", 64'(s_resp_data), 64'(0));
    l2_resp_valid = 1'b1;
    l2_resp_data = 32'h5555_AAAA;
    tick();
    l2_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_resp_valid", 64'(s_resp_valid), 64'(0));
      chk("late_busy", 64'(s_busy), 64'(0));
    end

    // Reset while client 0 is in flight (rr_ptr would otherwise be 1).
    req_addr[31:0] = 32'h0000_1100;
    req_valid = 2'b01;
    for (int i = 0; i < 20 && s_l2_valid !== 1'b1; i++) tick();
    chk("rst_pre_busy", 64'(s_l2_valid), 64'(1));
    rst = 1'b1;
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    l2_resp_valid = 1'b1;
    l2_resp_data = 32'h7777_7777;
    tick();
    chk_all_zero("rst_mid");
    l2_resp_valid = 1'b0;
    tick();
    chk("rst_late_resp", 64'(s_resp_valid), 64'(0));
    req_addr = {32'h0000_4400, 32'h0000_4000};
    req_valid = 2'b11;
    serve(2, 32'h0000_0001, bn, g, a, op, wd);
    chk("rst_regrant", 64'(g), 64'(0));
    chk("rst_regrant_addr", 64'(a), 64'h4000);
    serve(2, 32'h0000_0002, bn, g, a, op, wd);
    chk("rst_second", 64'(g), 64'(1));
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
